// File: rtl/slow_clock_pkg.sv
// Shared serial constants: system clock, baud rate
// and the default clocks-per-bit divider.
package slow_clock_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD = 115_200;
  localparam int unsigned DIV_DEFAULT = CLK_HZ / BAUD;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one async level.
// Resets to 1 so an idle-high line sees no edge.
module sync_2ff (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/slow_clock.sv
// Bit-rate clock recovered from a serial line.
// SCLK falls mid-bit; every line edge restarts the period.
module slow_clock
  import slow_clock_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SYNC,
  output logic SCLK
);

  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

  logic          s2;
  logic          s3_q, s3_d;
  logic          sync_edge;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          sclk_q, sclk_d;

  sync_2ff u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (SYNC),
    .q     (s2)
  );

  assign sync_edge = s2 ^ s3_q;
  assign cnt_inc = cnt_q + CW'(1);

  // A line edge outranks the period wrap so resync is immediate.
  always_comb begin
    s3_d   = s2;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (sync_edge) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else begin
      cnt_d = cnt_inc;
      if (cnt_inc == CNT_HALF) begin
        sclk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s3_q   <= 1'b1;
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      s3_q   <= s3_d;
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign SCLK = sclk_q;

endmodule

// File: tb/tb_slow_clock.sv
// Scoreboard bench for slow_clock at DIV=8:
// directed per-edge SCLK/cnt vectors plus a UART 0x55 frame.
module tb_slow_clock;

  localparam int DIV = 8;
  localparam int HALF = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic SYNC = 1'b1;
  logic SCLK;

  slow_clock #(.DIV(DIV)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SYNC  (SYNC),
    .SCLK  (SCLK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit    cs;
    logic  es;
    bit    cc;
    int    ec;
    string nm;
  } exp_t;

  exp_t sb_q[$];
  logic rx_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;

  logic       rx_on = 1'b0;
  int         rx_from = 0;
  int         frame_start = 0;
  int         rx_n = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       prev_sclk = 1'b1;
  exp_t       mon_e;
  logic       exp_b;
  int         off;

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: pops one expectation per cycle, and runs the
  // mid-bit receiver on each SCLK fall.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cs) check({mon_e.nm, "_sclk"}, 32'(SCLK), 32'(mon_e.es));
      if (mon_e.cc) check({mon_e.nm, "_cnt"}, 32'(dut.cnt_q), 32'(mon_e.ec));
    end
    if (rx_on && prev_sclk === 1'b1 && SCLK === 1'b0 &&
        edge_n >= rx_from && rx_n < 10) begin
      exp_b = (rx_q.size() > 0) ? rx_q.pop_front() : 1'bx;
      check($sformatf("uart_bit%0d", rx_n), 32'(SYNC), 32'(exp_b));
      off = edge_n - (frame_start + DIV * rx_n + 2 + HALF);
      n_chk++;
      if (off >= -1 && off <= 1) n_pass++;
      else $display("FAIL uart_pos%0d: offset %0d required -1..1", rx_n, off);
      if (rx_n >= 1 && rx_n <= 8) rx_byte[rx_n-1] = SYNC;
      rx_n++;
    end
    prev_sclk = SCLK;
  end

  task automatic step(input byte s, input byte e, input byte c,
                      input string nm);
    exp_t x;
    @(posedge CLK);
    #1;
    x.cs = (e != ".");
    x.es = (e == "1");
    x.cc = (c != ".");
    x.ec = int'(c) - int'("0");
    x.nm = nm;
    sb_q.push_back(x);
    if (s == "0") SYNC = 1'b0;
    else if (s == "1") SYNC = 1'b1;
  endtask

  task automatic run_vec(input string nm, input string sv,
                         input string ev, input string cv);
    byte e, c;
    for (int i = 0; i < sv.len(); i++) begin
      e = (i < ev.len()) ? ev[i] : ".";
      c = (i < cv.len()) ? cv[i] : ".";
      step(sv[i], e, c, $sformatf("%s%0d", nm, i));
    end
  endtask

  function automatic string rep(input string s, input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  initial begin
    logic [9:0] frame;
    byte        ch;

    // Reset held: SCLK high, cnt zero.
    run_vec("rst", "111", "111", "000");
    step("1", "1", "0", "rst_last");
    RST_N = 1'b1;

    // Idle line: first fall on 4th edge, period 8.
    run_vec("idle", rep("1", 40), rep("11100001", 5), "...4...0");

    // 1->0 landing while SCLK low: rise at k+2, fall k+6, rise k+10.
    run_vec("resync_low", "1000000000000",
            "1110111100001", "....0");

    // Toggle while cnt=6: resync, next fall 4 edges later.
    run_vec("resync_c6", "00000111111111111",
            "11100001111100001", "........0...4");

    // Toggling every cycle holds SCLK high, then period resumes.
    run_vec("burst", {"0101010101", rep("1", 15)},
            "1111111111111111000011110", ".......0....0...4");

    // Async reset pulse between edges while SCLK low.
    step("1", "1", "0", "rst_pulse");
    #1 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    run_vec("post_rst", rep("1", 16), "1110000111100001", "...4...0");

    // UART frame 0x55: start, data LSB first, stop.
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < DIV; c++) begin
        ch = frame[b] ? "1" : "0";
        step(ch, ".", ".", "uart");
        if (c == 0) rx_q.push_back(frame[b]);
        if (b == 0 && c == 0) begin
          frame_start = edge_n;
          rx_from = edge_n + 3;
          rx_on = 1'b1;
        end
      end
    end
    run_vec("tail", rep("1", 20), "", "");
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("uart_nsamples", 32'(rx_n), 32'd10);
    check("uart_byte", 32'(rx_byte), 32'h55);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
